rca_seq_ctrl: RTL
=================

# rca_seq_ctrl

Sequencing controller that reuses one shared N-bit ripple-carry adder (`rca_generic`, reached through the `rca_if` wrapper) to perform multi-precision additions word by word. Operands stream in least-significant word first over a valid/ready handshake. The carry is held in a register between words, and each per-word sum is produced on a registered valid/ready output stream. The block sits between the operand source and the consumer; the adder itself stays combinational and external.

## Interface
- `N`, default 4: adder and word width in bits.
- `MAX_WORDS`, default 8: maximum words per operation; must be ≥1.
- `CNT_W`, default 3: word-index width, equal to clog2(MAX_WORDS) with a minimum of 1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand word valid.
- `in_ready`  out  1  operand word accepted when high together with `in_valid`.
- `in_a`, `in_b`  in  N  operand words.
- `in_last`  in  1  marks the most-significant word of the operation.
- `in_ci`  in  1  carry-in for the operation; sampled on the first word only.
- `in_sub`  in  1  subtract request; sampled on the first word only (see Configuration).
- `rca_a`, `rca_b`  out  N  operands driven to the adder (combinational).
- `rca_ci`  out  1  carry-in driven to the adder.
- `rca_s`  in  N  sum returned from the adder.
- `rca_co`  in  1  carry-out returned from the adder.
- `out_valid`  out  1  result word valid.
- `out_ready`  in  1  consumer accepts the result word.
- `out_s`  out  N  registered sum word.
- `out_idx`  out  CNT_W  word index within the operation, 0 = least significant.
- `out_last`  out  1  final word of the operation.
- `out_co`  out  1  final carry-out; meaningful only when `out_last` is 1, otherwise 0.
- `out_err`  out  1  the operation was truncated at MAX_WORDS (set with `out_last`).

## Operation
- State register `st` has two values:
  - IDLE: the next accepted word is the first word of an operation.
  - RUN: the operation is mid-stream.
- Internal registers: `carry_q`, `sub_q`, `idx_q`.
- Acceptance: `acc = in_valid && in_ready`, where `in_ready = !out_valid || out_ready`. The output register is a single-entry skid and the block has no other buffering.
- Adder drive:
  - `rca_a = in_a`.
  - `rca_b = in_b`, XOR-ed with `sub_eff` when subtraction is compiled in.
  - `rca_ci` is `in_ci | sub_eff` in IDLE and `carry_q` in RUN.
  - `sub_eff` is `in_sub` in IDLE and `sub_q` in RUN.
  - The adder is driven continuously, but only `acc` cycles matter.
- On `acc`:
  - `out_s <= rca_s`.
  - `out_idx <= idx` (0 in IDLE, `idx_q` in RUN).
  - `carry_q <= rca_co`.
  - `out_valid <= 1`.
- Termination: the word is the last one if `in_last` is set, or if idx == MAX_WORDS-1 without `in_last`. In the second case the operation is forced to end and `out_err` is set.
- On the last word:
  - `out_last <= 1` and `out_co <= rca_co`.
  - `st <= IDLE`, `idx_q <= 0`.
- On any other word:
  - `st <= RUN` and `idx_q <= idx + 1`.
  - `sub_q` is latched from `in_sub` when the word is the first one.
- Output drain: `out_ready && out_valid && !acc` clears `out_valid`, `out_last`, `out_err` and `out_co`. When a new word is accepted in the same cycle, the new values overwrite the old ones.
- In RUN, `in_ci` and `in_sub` are ignored.

## Timing
- Reset values: `out_valid`, `out_last`, `out_co`, `out_err` = 0; `out_s` and `out_idx` = 0; `st` = IDLE; `carry_q`, `sub_q`, `idx_q` = 0.
- `in_ready` is 1 after reset.
- Latency: a word accepted in cycle t appears on the output with `out_valid` = 1 in cycle t+1.
- Throughput: one word per cycle while `out_ready` stays 1.
- Backpressure: with `out_ready` = 0 and `out_valid` = 1, `in_ready` = 0 and all state holds. Outputs must stay stable while `out_valid && !out_ready`.
- `in_ready` depends combinationally on `out_ready`. There is no other combinational path from input to output handshake.
- The adder path is combinational within the accept cycle and lies between the `in_*` ports and the output register.
- Back-to-back operations: a word with `in_last` followed in the next cycle by a new first word is legal, with no bubble. The new first word uses `in_ci` and never `carry_q`.
- Asserting `rst_n` low mid-operation discards the partial result immediately and returns all registers to their reset values. No output is produced for the aborted operation.
- MAX_WORDS = 1: every word is both first and last. `out_err` is 1 only if `in_last` = 0.

## Configuration
- `RCA_SEQ_SUB_EN` defined:
  - `in_sub` is honoured. Subtraction computes A − B as A + ~B with carry-in `1 | in_ci`.
  - `out_co` = 1 means no borrow.
- `RCA_SEQ_SUB_EN` undefined:
  - `in_sub` is ignored, `sub_q` is not implemented, and `rca_b = in_b` always.
  - First-word carry-in is `in_ci`.

## Test plan
- N=4, one word, A=0x9, B=0x8, ci=0, last=1 -> next cycle `out_s`=0x1, `out_co`=1, `out_last`=1, `out_idx`=0, `out_err`=0.
- Three words, A=0xFFF, B=0x001 (LS word first), ci=0 -> outputs 0x0, 0x0, 0x0 with idx 0, 1, 2; final `out_co`=1; carry propagates across the word boundaries.
- Two-word operation immediately followed by a second operation with ci=1, A=0x0, B=0x0 -> second result `out_s`=0x1, `out_co`=0. Checks that the stale carry is not reused.
- Hold `out_ready`=0 for 3 cycles mid-stream -> `in_ready`=0, `out_s`/`out_idx` stable, no word lost or duplicated; stream resumes correctly.
- MAX_WORDS=8 stream of 9 words with no `in_last` -> 8th word has `out_last`=1 and `out_err`=1; 9th word starts a new operation at idx 0. With `RCA_SEQ_SUB_EN`: A=0x3, B=0x5 -> `out_s`=0xE, `out_co`=0.
- Pull `rst_n` low mid-operation -> outputs return to 0 asynchronously; next first word uses `in_ci` and `out_idx`=0.

Source files
------------

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: word-serial multi-precision add sequencer around an external
// combinational ripple-carry adder. Operands arrive LS word first; the carry
// is held between words and each sum word leaves through a one-entry
// registered valid/ready output stage.
// Optional feature: define RCA_SEQ_SUB_EN to honour in_sub (A - B as A + ~B + 1).
module rca_seq_ctrl #(
  parameter int N         = 4,
  parameter int MAX_WORDS = 8,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_last,
  input  logic             in_ci,
  input  logic             in_sub,
  output logic [N-1:0]     rca_a,
  output logic [N-1:0]     rca_b,
  output logic             rca_ci,
  input  logic [N-1:0]     rca_s,
  input  logic             rca_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_s,
  output logic [CNT_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_co,
  output logic             out_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } st_e;

  localparam logic [CNT_W-1:0] IDX_MAX = CNT_W'(MAX_WORDS - 1);
  localparam logic [CNT_W-1:0] IDX_ONE = CNT_W'(1);

  st_e              st_q, st_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_s_q, out_s_d;
  logic [CNT_W-1:0] out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
  logic             out_co_q, out_co_d;
  logic             out_err_q, out_err_d;

  logic             acc;
  logic             first;
  logic [CNT_W-1:0] idx;
  logic             force_end;
  logic             is_last;
  logic             sub_eff;

`ifdef RCA_SEQ_SUB_EN
  logic             sub_q, sub_d;

  // Subtract mode comes from the port on the first word, from the latch after
  always_comb begin
    sub_eff = first ? in_sub : sub_q;
  end
`else
  logic             unused_sub;

  // Subtraction not built: in_sub is deliberately left unconnected
  always_comb begin
    sub_eff    = 1'b0;
    unused_sub = in_sub;
  end
`endif

  // Word position within the current operation and termination decision
  always_comb begin
    first     = (st_q == IDLE);
    idx       = first ? '0 : idx_q;
    force_end = !in_last && (idx == IDX_MAX);
    is_last   = in_last || force_end;
    acc       = in_valid && in_ready;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  // Next state: any accepted last word returns to IDLE, any other enters RUN
  always_comb begin
    st_d = st_q;
    if (acc) st_d = is_last ? IDLE : RUN;
  end

  // Output/handshake and adder drive
  always_comb begin
    in_ready = !out_valid_q || out_ready;
    rca_a    = in_a;
    rca_b    = in_b ^ {N{sub_eff}};
    rca_ci   = first ? (in_ci | sub_eff) : carry_q;
  end

  // Datapath next values: a new word overwrites the skid, otherwise drain clears flags
  always_comb begin
    carry_d     = carry_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_s_d     = out_s_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_co_d    = out_co_q;
    out_err_d   = out_err_q;
`ifdef RCA_SEQ_SUB_EN
    sub_d       = sub_q;
`endif
    if (acc) begin
      out_s_d     = rca_s;
      out_idx_d   = idx;
      carry_d     = rca_co;
      out_valid_d = 1'b1;
      out_last_d  = is_last;
      out_co_d    = is_last ? rca_co : 1'b0;
      out_err_d   = force_end;
      if (is_last) begin
        idx_d = '0;
      end else begin
        idx_d = idx + IDX_ONE;
`ifdef RCA_SEQ_SUB_EN
        if (first) sub_d = in_sub;
`endif
      end
    end else if (out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_co_d    = 1'b0;
      out_err_d   = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q     <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_co_q    <= 1'b0;
      out_err_q   <= 1'b0;
`ifdef RCA_SEQ_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_s_q     <= out_s_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_co_q    <= out_co_d;
      out_err_q   <= out_err_d;
`ifdef RCA_SEQ_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_co    = out_co_q;
  assign out_err   = out_err_q;

endmodule
